sample_fifo: RTL and testbench

- Synchronous first-word-fall-through (FWFT) sample buffer.
- Sits directly upstream of the PSK/PWM modulator and drives its FIFO interface (`sample`, `empty`, `read`).
- Absorbs bursty byte writes from the host/packetizer side so the modulator can pull one symbol byte per symbol period without gaps.

---
 rtl/sample_fifo_if.sv | 27 ++
 rtl/sample_fifo.sv | 117 +++++++++++
 tb/tb_sample_fifo.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_fifo_if.sv
// Handshake bundle between sample_fifo and its producer/modulator.
// Master = host writer + modulator reader; slave = the FIFO.
interface sample_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  write;
  logic                  read;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] sample;
  logic [LW-1:0]         level;

  modport master (
    output wr_data, write, read,
    input  full, almost_full, empty, sample, level
  );

  modport slave (
    input  wr_data, write, read,
    output full, almost_full, empty, sample, level
  );
endinterface

// File: rtl/sample_fifo.sv
// FWFT sample buffer feeding the PSK/PWM modulator.
// SAMPLE_FIFO_ERR_FLAGS_EN adds overflow/underflow/drop_count outputs.
module sample_fifo #(
  parameter int DATA_WIDTH        = 8,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic clk,
  input  logic rst,
  sample_fifo_if.slave f
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
  ,
  output logic       overflow,
  output logic       underflow,
  output logic [7:0] drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [LW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_sample;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_afull;

  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [AW-1:0]         w_rptr_inc;
  logic [LW-1:0]         w_count_nxt;
  logic [DATA_WIDTH-1:0] w_sample_nxt;

  assign w_rd_ok    = f.read & ~r_empty;
  assign w_wr_ok    = f.write & (~r_full | w_rd_ok);
  assign w_rptr_inc = r_rptr + AW'(1);

  // Next occupancy and next head; a write into an empty
  // (or just-emptied) FIFO bypasses memory onto sample.
  always_comb begin
    w_count_nxt  = r_count;
    w_sample_nxt = r_sample;
    unique case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + LW'(1);
      2'b01:   w_count_nxt = r_count - LW'(1);
      default: w_count_nxt = r_count;
    endcase
    if (w_rd_ok) begin
      if (r_count == LW'(1)) begin
        if (w_wr_ok) w_sample_nxt = f.wr_data;
      end else begin
        w_sample_nxt = r_mem[w_rptr_inc];
      end
    end else if (r_empty && w_wr_ok) begin
      w_sample_nxt = f.wr_data;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= f.wr_data;
  end

  // Pointers, occupancy, registered head and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_sample <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
      if (w_rd_ok) r_rptr <= w_rptr_inc;
      r_count  <= w_count_nxt;
      r_sample <= w_sample_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == LW'(DEPTH));
      r_afull  <= (w_count_nxt >= LW'(ALMOST_FULL_LEVEL));
    end
  end

  assign f.sample      = r_sample;
  assign f.empty       = r_empty;
  assign f.full        = r_full;
  assign f.almost_full = r_afull;
  assign f.level       = r_count;

`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
  logic       r_ovf;
  logic       r_udf;
  logic [7:0] r_drops;

  // Sticky error flags and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_drops <= '0;
    end else begin
      if (f.write && !w_wr_ok) begin
        r_ovf <= 1'b1;
        if (r_drops != 8'hFF) r_drops <= r_drops + 8'd1;
      end
      if (f.read && r_empty) r_udf <= 1'b1;
    end
  end

  assign overflow   = r_ovf;
  assign underflow  = r_udf;
  assign drop_count = r_drops;
`endif
endmodule

// File: tb/tb_sample_fifo.sv
// Randomized self-checking bench for sample_fifo.
// Reference model: a queue of stored bytes.
module tb_sample_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int LW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sample_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) f ();

`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
  logic       ovf;
  logic       udf;
  logic [7:0] dcnt;
`endif

  sample_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ALMOST_FULL_LEVEL(AFL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .f(f)
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    ,
    .overflow(ovf),
    .underflow(udf),
    .drop_count(dcnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_sample;
  bit         m_ovf;
  bit         m_udf;
  int         m_drops;

  logic [15:0] dvec;
  assign dvec = {f.empty, f.full, f.almost_full, f.level, f.sample};

  function automatic logic [15:0] evec();
    int n;
    n = q.size();
    return {(n == 0), (n == DEPTH), (n >= AFL), LW'(n), m_sample};
  endfunction

  task automatic model_reset();
    q.delete();
    m_sample = '0;
    m_ovf    = 0;
    m_udf    = 0;
    m_drops  = 0;
  endtask

  task automatic tick(input logic w, input logic r, input logic [7:0] d);
    bit rd_ok;
    bit wr_ok;
    f.write   = w;
    f.read    = r;
    f.wr_data = d;
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    @(posedge clk);
    #1;
    if (rd_ok) void'(q.pop_front());
    if (wr_ok) q.push_back(d);
    if (w && !wr_ok) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
    if (r && !rd_ok) m_udf = 1;
    if (q.size() > 0) m_sample = q[0];
    f.write = 1'b0;
    f.read  = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (dvec !== 16'h8000) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", dvec, 16'h8000);
    end
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    checks++;
    if ({ovf, udf, dcnt} !== 10'd0) begin
      errors++;
      $display("FAIL reset_errflags got=%b", {ovf, udf, dcnt});
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    tick(1'b1, 1'b0, 8'hA5);
    checks++;
    if (dvec !== evec() || f.sample !== 8'hA5) begin
      errors++;
      $display("FAIL single_write got=%h exp=%h", dvec, evec());
    end
    tick(1'b0, 1'b1, 8'h00);
    checks++;
    if (dvec !== evec() || f.empty !== 1'b1) begin
      errors++;
      $display("FAIL single_read got=%h exp=%h", dvec, evec());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 1'b0, 8'(i));
      checks++;
      if (dvec !== evec()) begin
        errors++;
        $display("FAIL fill_%0d got=%h exp=%h", i, dvec, evec());
      end
    end
    tick(1'b1, 1'b0, 8'hFF);
    checks++;
    if (dvec !== evec() || f.full !== 1'b1) begin
      errors++;
      $display("FAIL drop_when_full got=%h exp=%h", dvec, evec());
    end
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    checks++;
    if (ovf !== 1'b1 || dcnt !== 8'(m_drops)) begin
      errors++;
      $display("FAIL overflow_flag got=%b/%0d exp=1/%0d",
               ovf, dcnt, m_drops);
    end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (f.sample !== 8'(i)) begin
        errors++;
        $display("FAIL drain_order_%0d got=%h exp=%h",
                 i, f.sample, 8'(i));
      end
      tick(1'b0, 1'b1, 8'h00);
    end
    checks++;
    if (dvec !== evec()) begin
      errors++;
      $display("FAIL drained got=%h exp=%h", dvec, evec());
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] last;
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 8'($urandom));
    tick(1'b1, 1'b1, 8'h55);
    checks++;
    if (dvec !== evec() || f.full !== 1'b1 || f.level !== 5'd16) begin
      errors++;
      $display("FAIL full_rw got=%h exp=%h", dvec, evec());
    end
    last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last = f.sample;
      tick(1'b0, 1'b1, 8'h00);
      checks++;
      if (dvec !== evec()) begin
        errors++;
        $display("FAIL full_rw_drain_%0d got=%h exp=%h",
                 i, dvec, evec());
      end
    end
    checks++;
    if (last !== 8'h55) begin
      errors++;
      $display("FAIL full_rw_last got=%h exp=55", last);
    end
  endtask

  task automatic test_empty();
    logic [7:0] prev;
    prev = f.sample;
    tick(1'b0, 1'b1, 8'h00);
    checks++;
    if (dvec !== evec() || f.sample !== prev) begin
      errors++;
      $display("FAIL read_empty got=%h exp=%h", dvec, evec());
    end
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    checks++;
    if (udf !== 1'b1) begin
      errors++;
      $display("FAIL underflow_flag got=%b exp=1", udf);
    end
`endif
    tick(1'b1, 1'b1, 8'h3C);
    checks++;
    if (dvec !== evec() || f.sample !== 8'h3C || f.level !== 5'd1) begin
      errors++;
      $display("FAIL rw_empty got=%h exp=%h", dvec, evec());
    end
    tick(1'b1, 1'b1, 8'h4D);
    checks++;
    if (dvec !== evec() || f.sample !== 8'h4D || f.level !== 5'd1) begin
      errors++;
      $display("FAIL rw_one got=%h exp=%h", dvec, evec());
    end
    tick(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_stream();
    logic [7:0] got[$];
    int nxt;
    int cyc;
    bit w;
    bit r;
    int drops0;
    nxt    = 0;
    cyc    = 0;
    drops0 = m_drops;
    while (got.size() < 40 && cyc < 2000) begin
      w = (nxt < 40) && (q.size() < DEPTH) && ($urandom_range(3) != 0);
      r = (cyc % 4 == 3);
      if (r && !f.empty) got.push_back(f.sample);
      tick(w, r, 8'(8'h10 + nxt));
      if (w) nxt++;
      cyc++;
      checks++;
      if (dvec !== evec()) begin
        errors++;
        $display("FAIL stream_cyc%0d got=%h exp=%h", cyc, dvec, evec());
      end
    end
    checks++;
    if (got.size() != 40) begin
      errors++;
      $display("FAIL stream_timeout got=%0d exp=40", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL stream_data_%0d got=%h exp=%h",
                 i, got[i], 8'(8'h10 + i));
      end
    end
    checks++;
    if (m_drops != drops0 || q.size() != 0) begin
      errors++;
      $display("FAIL stream_drops got=%0d exp=%0d", m_drops, drops0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(2) != 0), 1'($urandom_range(2) == 0),
           8'($urandom));
      checks++;
      if (dvec !== evec()) begin
        errors++;
        $display("FAIL random_%0d got=%h exp=%h", i, dvec, evec());
      end
    end
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    checks++;
    if ({ovf, udf, dcnt} !== {m_ovf, m_udf, 8'(m_drops)}) begin
      errors++;
      $display("FAIL random_errflags got=%b exp=%b",
               {ovf, udf, dcnt}, {m_ovf, m_udf, 8'(m_drops)});
    end
`endif
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 40 && q.size() > 0; i++) tick(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 8'($urandom));
    checks++;
    if (dvec !== evec() || f.level !== 5'd9) begin
      errors++;
      $display("FAIL fill9 got=%h exp=%h", dvec, evec());
    end
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dvec !== 16'h8000) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", dvec, 16'h8000);
    end
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    checks++;
    if ({ovf, udf, dcnt} !== 10'd0) begin
      errors++;
      $display("FAIL async_errflags got=%b", {ovf, udf, dcnt});
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1'b1, 1'b0, 8'h77);
    checks++;
    if (dvec !== evec() || f.sample !== 8'h77 || f.level !== 5'd1) begin
      errors++;
      $display("FAIL post_reset got=%h exp=%h", dvec, evec());
    end
  endtask

  initial begin
    f.write   = 1'b0;
    f.read    = 1'b0;
    f.wr_data = '0;
    model_reset();
    test_reset();
    test_single();
    test_fill();
    test_full_rw();
    test_empty();
    test_stream();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
